// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access unit.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_TAG_W  = 3;
    localparam int DMEM_DEPTH  = 2 ** DMEM_ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_access_unit.sv
// Memory-stage controller in front of the single-port data RAM:
// zero-sweep after reset or on request, then range-checked load/store.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int TAG_W  = DMEM_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_fault,
    input  logic              clr_start,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_fault_q, rsp_fault_d;

    logic run;
    logic fault;
    logic accept;

    assign run    = (state_q == RUN);
    assign fault  = |req_addr[DATA_W-1:ADDR_W];
    assign busy   = !run;

    // A clear request wins over any request presented in the same cycle.
    assign req_ready = run && !clr_start
                       && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign ram_add = run ? req_addr[ADDR_W-1:0] : clr_cnt_q;
    assign ram_din = run ? req_wdata : '0;
    assign ram_we  = !run || (accept && req_we && !fault);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_fault_d = rsp_fault_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (req_we || fault) ? '0 : ram_dout;
            rsp_tag_d   = req_tag;
            rsp_fault_d = fault;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_tag_q   <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: attached RAM, behavioural model
// checked every cycle, plus directed literal checks.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_tag;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [15:0] rsp_rdata;
    logic [2:0]  rsp_tag;
    logic        clr_start, busy;
    logic [7:0]  ram_add;
    logic [15:0] ram_din, ram_dout;
    logic        ram_we;

    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_tag   (rsp_tag),
        .rsp_fault (rsp_fault),
        .clr_start (clr_start),
        .busy      (busy),
        .ram_add   (ram_add),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    // The RAM the parent would instantiate.
    assign ram_dout = mem[ram_add];
    always @(posedge clk) if (ram_we) mem[ram_add] <= ram_din;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: clearing flag with sweep index, a word array,
    // and the expected response contents.
    bit          m_clr;
    int          m_cnt;
    bit          m_v;
    logic [15:0] m_rd;
    logic [2:0]  m_tag;
    bit          m_f;
    logic [15:0] ref_mem [0:255];
    bit          e_busy, e_rdy, e_we, acc;
    logic [7:0]  e_add;
    logic [15:0] e_din;
    int          a;

    always @(negedge clk) begin
        acc = 1'b0;
        if (!rst_n) begin
            m_clr = 1'b1; m_cnt = 0;
            m_v = 1'b0; m_rd = '0; m_tag = '0; m_f = 1'b0;
            ref_mem[0] = '0;
            e_busy = 1'b1; e_rdy = 1'b0; e_we = 1'b1;
            e_add = '0; e_din = '0;
        end else begin
            a      = int'(req_addr);
            e_busy = m_clr;
            e_rdy  = !m_clr && !clr_start && (!m_v || rsp_ready);
            acc    = req_valid && e_rdy;
            e_we   = m_clr || (acc && req_we && a < 256);
            e_add  = m_clr ? 8'(m_cnt) : 8'(a % 256);
            e_din  = m_clr ? 16'h0 : req_wdata;
        end
        chk("ctl", {busy, req_ready, ram_we, ram_add, ram_din},
            {e_busy, e_rdy, e_we, e_add, e_din});
        chk("rsp_valid", rsp_valid, m_v);
        if (m_v || !rst_n)
            chk("rsp_fields", {rsp_rdata, rsp_tag, rsp_fault}, {m_rd, m_tag, m_f});
        if (rst_n) begin
            if (m_clr) begin
                ref_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == 256) begin
                    m_clr = 1'b0;
                    m_cnt = 0;
                end
            end else if (clr_start) begin
                m_clr = 1'b1;
                m_cnt = 0;
            end
            if (acc) begin
                m_v   = 1'b1;
                m_tag = req_tag;
                m_f   = (a >= 256);
                if (req_we) begin
                    m_rd = '0;
                    if (!m_f) ref_mem[a] = req_wdata;
                end else begin
                    m_rd = m_f ? 16'h0 : ref_mem[a];
                end
            end else if (rsp_ready) begin
                m_v = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit we, input logic [15:0] ad,
                        input logic [15:0] wd, input logic [2:0] tg);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ad;
        req_wdata = wd;
        req_tag   = tg;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic rsp_is(input string nm, input logic [15:0] rd,
                          input logic [2:0] tg, input bit f);
        chk(nm, {rsp_valid, rsp_rdata, rsp_tag, rsp_fault}, {1'b1, rd, tg, f});
    endtask

    task automatic sweep_check(input string nm);
        for (int i = 0; i < 256; i++) begin
            chk({nm, "_busy"}, busy, 1);
            chk({nm, "_we"}, ram_we, 1);
            chk({nm, "_add"}, ram_add, i);
            cyc();
        end
        chk({nm, "_done"}, {busy, req_ready}, 2'b01);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0;
        rsp_ready = 1'b1; clr_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            {busy, req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_fault, ram_we, ram_add},
            {1'b1, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0, 1'b1, 8'h0});
        rst_n = 1'b1;
        sweep_check("por");

        send(1'b1, 16'h0042, 16'hBEEF, 3'd5);
        rsp_is("st42", 16'h0, 3'd5, 1'b0);
        send(1'b0, 16'h0042, 16'h0, 3'd2);
        rsp_is("ld42", 16'hBEEF, 3'd2, 1'b0);
        send(1'b1, 16'h0142, 16'h1234, 3'd1);
        rsp_is("st142", 16'h0, 3'd1, 1'b1);
        chk("ram42_kept", mem[8'h42], 16'hBEEF);
        send(1'b0, 16'h0142, 16'h0, 3'd3);
        rsp_is("ld142", 16'h0, 3'd3, 1'b1);
        send(1'b0, 16'h0042, 16'h0, 3'd4);
        rsp_is("ld42b", 16'hBEEF, 3'd4, 1'b0);

        send(1'b1, 16'h0010, 16'h1111, 3'd0);
        send(1'b1, 16'h0011, 16'h2222, 3'd0);
        send(1'b1, 16'h0012, 16'h3333, 3'd0);
        send(1'b0, 16'h0010, 16'h0, 3'd1);
        rsp_is("b2b_0", 16'h1111, 3'd1, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0011; req_tag = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b_stall_rdy", req_ready, 0);
            rsp_is("b2b_hold", 16'h1111, 3'd1, 1'b0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_is("b2b_1", 16'h2222, 3'd2, 1'b0);
        req_addr = 16'h0012; req_tag = 3'd3;
        cyc();
        rsp_is("b2b_2", 16'h3333, 3'd3, 1'b0);
        req_valid = 1'b0;
        cyc();
        chk("b2b_drain", rsp_valid, 0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0042; req_tag = 3'd6;
        clr_start = 1'b1;
        #1;
        chk("clr_blocks_req", req_ready, 0);
        cyc();
        clr_start = 1'b0; req_valid = 1'b0;
        chk("clr_no_accept", rsp_valid, 0);
        n = 0;
        while (busy && n < 300) begin
            n++;
            cyc();
        end
        chk("clr_len", n, 256);
        send(1'b0, 16'h0042, 16'h0, 3'd7);
        rsp_is("ld42_cleared", 16'h0, 3'd7, 1'b0);

        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        repeat (100) cyc();
        chk("midclr_add", ram_add, 100);
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        sweep_check("rst");

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 31));
            req_wdata = 16'($urandom);
            req_tag   = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            clr_start = ($urandom_range(0, 399) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            cyc();
        end
        rst_n = 1'b1; req_valid = 1'b0; clr_start = 1'b0; rsp_ready = 1'b1;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
